mem_wb_stage: RTL and testbench

- MEM/WB pipeline register of the 5-stage MIPS datapath.
- Captures the MEM-stage result each cycle and performs load-data lane extraction with sign/zero extension.
- Selects the final writeback value: ALU result, loaded data, or link address.
- Drives the registered RegWrite/RegDst/WriteData that the register file write port and the WB-stage forwarding unit consume, and keeps a retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 129 ++++++++++++
 tb/tb_mem_wb_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register for the 5-stage MIPS datapath.
// Extracts the load lane with sign/zero extension, selects the writeback
// value (link address, load data or ALU result), registers the register-file
// write request and counts retired instructions with a saturating counter.
module mem_wb_stage #(
  parameter int DATA_W = 32,  // lane logic below is written for 32 bits only
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Stall,
  input  logic              Flush,
  input  logic              MemValid,
  input  logic              RegWriteIn,
  input  logic              MemToRegIn,
  input  logic              LinkIn,
  input  logic [1:0]        MemSizeIn,
  input  logic              MemSignedIn,
  input  logic [REG_AW-1:0] RegDstIn,
  input  logic [DATA_W-1:0] AluResultIn,
  input  logic [DATA_W-1:0] MemReadDataIn,
  input  logic [DATA_W-1:0] PCPlus8In,
  output logic              RegWrite,
  output logic [REG_AW-1:0] RegDst,
  output logic [DATA_W-1:0] WriteData,
  output logic              Valid,
  output logic [CNT_W-1:0]  RetireCount
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Stage state and its next-state values.
  logic              reg_write_q, reg_write_d;
  logic [REG_AW-1:0] reg_dst_q,   reg_dst_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic              valid_q,     valid_d;
  logic [CNT_W-1:0]  retire_cnt_q, retire_cnt_d;

  // Load extraction and writeback-value selection.
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] wb_val;
  logic              retire;

  // Pick the addressed byte/half lane (little-endian) and extend it.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    byte_lane = MemReadDataIn[7:0];
    case (AluResultIn[1:0])
      2'd1:    byte_lane = MemReadDataIn[15:8];
      2'd2:    byte_lane = MemReadDataIn[23:16];
      2'd3:    byte_lane = MemReadDataIn[31:24];
      default: byte_lane = MemReadDataIn[7:0];
    endcase

    // Half loads ignore offset bit 0; there is no misalignment trap.
    half_lane = AluResultIn[1] ? MemReadDataIn[31:16] : MemReadDataIn[15:0];

    case (MemSizeIn)
      SIZE_BYTE: load_val = {{24{MemSignedIn & byte_lane[7]}}, byte_lane};
      SIZE_HALF: load_val = {{16{MemSignedIn & half_lane[15]}}, half_lane};
      default:   load_val = MemReadDataIn;  // word, and 11 treated as word
    endcase
  end

  // Writeback source priority: link address, then load data, then ALU.
  always_comb begin
    if (LinkIn)          wb_val = PCPlus8In;
    else if (MemToRegIn) wb_val = load_val;
    else                 wb_val = AluResultIn;
  end

  // Next stage contents: Flush inserts a bubble, Stall holds, else load.
  always_comb begin
    reg_write_d  = reg_write_q;
    reg_dst_d    = reg_dst_q;
    write_data_d = write_data_q;
    valid_d      = valid_q;
    if (Flush) begin
      reg_write_d  = 1'b0;
      reg_dst_d    = '0;
      write_data_d = '0;
      valid_d      = 1'b0;
    end else if (!Stall) begin
      // A write to r0 is suppressed here so the forwarding unit never sees it.
      reg_write_d  = RegWriteIn & MemValid & (RegDstIn != '0);
      reg_dst_d    = RegDstIn;
      write_data_d = wb_val;
      valid_d      = MemValid;
    end
  end

  // The resident instruction retires whenever it leaves the stage;
  // the counter sticks at all-ones instead of wrapping.
  always_comb begin
    retire       = valid_q & (~Stall | Flush);
    retire_cnt_d = retire_cnt_q;
    if (retire && (retire_cnt_q != {CNT_W{1'b1}}))
      retire_cnt_d = retire_cnt_q + 1'b1;
  end

  // Stage registers with asynchronous active-high reset.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      reg_write_q  <= 1'b0;
      reg_dst_q    <= '0;
      write_data_q <= '0;
      valid_q      <= 1'b0;
      retire_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      reg_write_q  <= reg_write_d;
      reg_dst_q    <= reg_dst_d;
      write_data_q <= write_data_d;
      valid_q      <= valid_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign RegWrite    = reg_write_q;
  assign RegDst      = reg_dst_q;
  assign WriteData   = write_data_q;
  assign Valid       = valid_q;
  assign RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: reset, ALU/load/link writeback,
// stall/flush behaviour and retire-counter saturation (CNT_W = 4).
module tb_mem_wb_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              Clk = 1'b0;
  logic              Rst;
  logic              Stall, Flush, MemValid, RegWriteIn, MemToRegIn, LinkIn;
  logic [1:0]        MemSizeIn;
  logic              MemSignedIn;
  logic [REG_AW-1:0] RegDstIn;
  logic [DATA_W-1:0] AluResultIn, MemReadDataIn, PCPlus8In;
  logic              RegWrite;
  logic [REG_AW-1:0] RegDst;
  logic [DATA_W-1:0] WriteData;
  logic              Valid;
  logic [CNT_W-1:0]  RetireCount;

  int n_checks = 0;
  int n_fail   = 0;

  // Small model of the retire counter: tracks stage occupancy and counts.
  logic             exp_valid;
  logic [CNT_W-1:0] exp_cnt;

  mem_wb_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .MemValid(MemValid),
    .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .LinkIn(LinkIn),
    .MemSizeIn(MemSizeIn), .MemSignedIn(MemSignedIn), .RegDstIn(RegDstIn),
    .AluResultIn(AluResultIn), .MemReadDataIn(MemReadDataIn),
    .PCPlus8In(PCPlus8In), .RegWrite(RegWrite), .RegDst(RegDst),
    .WriteData(WriteData), .Valid(Valid), .RetireCount(RetireCount)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic m2r,
                       input logic lnk, input logic [1:0] sz, input logic sg,
                       input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] mrd, input logic [31:0] pc8);
    MemValid = v; RegWriteIn = rw; MemToRegIn = m2r; LinkIn = lnk;
    MemSizeIn = sz; MemSignedIn = sg; RegDstIn = rd;
    AluResultIn = alu; MemReadDataIn = mrd; PCPlus8In = pc8;
  endtask

  // One clock edge; the counter model is advanced with the same inputs.
  task automatic step();
    if (exp_valid && (!Stall || Flush) && exp_cnt != 4'hF) exp_cnt++;
    if (Flush)       exp_valid = 1'b0;
    else if (!Stall) exp_valid = MemValid;
    @(posedge Clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".regwrite"}, {31'd0, RegWrite}, 32'd0);
    check({tag, ".regdst"},   {27'd0, RegDst},   32'd0);
    check({tag, ".wdata"},    WriteData,         32'd0);
    check({tag, ".valid"},    {31'd0, Valid},    32'd0);
    check({tag, ".count"},    {28'd0, RetireCount}, 32'd0);
  endtask

  // Reset pulse placed between edges, released 1 ns after an edge.
  task automatic pulse_reset();
    #2 Rst = 1'b1;
    @(posedge Clk);
    #1 Rst = 1'b0;
    exp_valid = 1'b0;
    exp_cnt   = '0;
  endtask

  localparam logic [31:0] LD_WORD = 32'h80FF_7F01;

  initial begin
    Rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
    exp_valid = 1'b0; exp_cnt = '0;
    drive(1, 1, 0, 0, 2'b10, 0, 5'd3, 32'h77, 32'h0, 32'h0);

    // Reset held across an edge with a valid instruction presented.
    #6;
    check_zero("rst_hold");
    #6 Rst = 1'b0;

    // 1. Reset mid-stream.
    drive(1, 1, 0, 0, 2'b10, 0, 5'd1, 32'h11, 32'h0, 32'h0); step();
    drive(1, 1, 0, 0, 2'b10, 0, 5'd2, 32'h22, 32'h0, 32'h0); step();
    drive(1, 1, 0, 0, 2'b10, 0, 5'd3, 32'h33, 32'h0, 32'h0); step();
    check("stream.valid", {31'd0, Valid}, 32'd1);
    check("stream.wdata", WriteData, 32'h33);
    check("stream.count", {28'd0, RetireCount}, 32'd2);
    #2 Rst = 1'b1;
    #1;
    check_zero("rst_async");
    @(posedge Clk);
    #1 Rst = 1'b0;
    exp_valid = 1'b0; exp_cnt = '0;

    // 2. ALU writeback, then the same with destination r0.
    drive(1, 1, 0, 0, 2'b10, 0, 5'd5, 32'h0000_1234, 32'h0, 32'h0); step();
    check("alu.regwrite", {31'd0, RegWrite}, 32'd1);
    check("alu.regdst",   {27'd0, RegDst},   32'd5);
    check("alu.wdata",    WriteData,         32'h1234);
    check("alu.valid",    {31'd0, Valid},    32'd1);
    drive(1, 1, 0, 0, 2'b10, 0, 5'd0, 32'h0000_1234, 32'h0, 32'h0); step();
    check("r0.regwrite",  {31'd0, RegWrite}, 32'd0);
    check("r0.regdst",    {27'd0, RegDst},   32'd0);

    // 3. Load lanes.
    drive(1, 1, 1, 0, 2'b00, 1, 5'd8, 32'h1, LD_WORD, 32'h0); step();
    check("lb_off1", WriteData, 32'h0000_007F);
    drive(1, 1, 1, 0, 2'b00, 1, 5'd8, 32'h2, LD_WORD, 32'h0); step();
    check("lb_off2", WriteData, 32'hFFFF_FFFF);
    drive(1, 1, 1, 0, 2'b00, 0, 5'd8, 32'h3, LD_WORD, 32'h0); step();
    check("lbu_off3", WriteData, 32'h0000_0080);
    drive(1, 1, 1, 0, 2'b00, 1, 5'd8, 32'h3, LD_WORD, 32'h0); step();
    check("lb_off3", WriteData, 32'hFFFF_FF80);
    drive(1, 1, 1, 0, 2'b00, 1, 5'd8, 32'h0, LD_WORD, 32'h0); step();
    check("lb_off0", WriteData, 32'h0000_0001);
    drive(1, 1, 1, 0, 2'b01, 1, 5'd8, 32'h2, LD_WORD, 32'h0); step();
    check("lh_off2", WriteData, 32'hFFFF_80FF);
    drive(1, 1, 1, 0, 2'b01, 1, 5'd8, 32'h3, LD_WORD, 32'h0); step();
    check("lh_off3", WriteData, 32'hFFFF_80FF);
    drive(1, 1, 1, 0, 2'b01, 0, 5'd8, 32'h2, LD_WORD, 32'h0); step();
    check("lhu_off2", WriteData, 32'h0000_80FF);
    drive(1, 1, 1, 0, 2'b01, 0, 5'd8, 32'h0, LD_WORD, 32'h0); step();
    check("lhu_off0", WriteData, 32'h0000_7F01);
    drive(1, 1, 1, 0, 2'b10, 1, 5'd8, 32'h1, LD_WORD, 32'h0); step();
    check("lw", WriteData, 32'h80FF_7F01);
    drive(1, 1, 1, 0, 2'b11, 1, 5'd8, 32'h2, LD_WORD, 32'h0); step();
    check("lw_size11", WriteData, 32'h80FF_7F01);

    // 4. Link beats load data.
    drive(1, 1, 1, 0, 2'b10, 0, 5'd31, 32'h4, LD_WORD, 32'h0040_0010);
    LinkIn = 1'b1; step();
    check("link.wdata",  WriteData, 32'h0040_0010);
    check("link.regdst", {27'd0, RegDst}, 32'd31);

    // Bubble from EX/MEM: fields load, no write, not valid.
    drive(0, 1, 0, 0, 2'b10, 0, 5'd9, 32'hBEEF, 32'h0, 32'h0); step();
    check("bubble.regwrite", {31'd0, RegWrite}, 32'd0);
    check("bubble.valid",    {31'd0, Valid},    32'd0);
    check("bubble.regdst",   {27'd0, RegDst},   32'd9);
    check("bubble.wdata",    WriteData,         32'hBEEF);

    // 5. Stall holds, Stall+Flush bubbles and retires the resident instruction.
    pulse_reset();
    drive(1, 1, 0, 0, 2'b10, 0, 5'd7, 32'hAAAA, 32'h0, 32'h0); step();
    check("A.wdata", WriteData, 32'hAAAA);
    check("A.count", {28'd0, RetireCount}, 32'd0);
    Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0, 2'b10, 0, 5'd9, 32'h5555 + i, 32'h0, 32'h0); step();
      check("stall.wdata",    WriteData,         32'hAAAA);
      check("stall.regdst",   {27'd0, RegDst},   32'd7);
      check("stall.regwrite", {31'd0, RegWrite}, 32'd1);
      check("stall.valid",    {31'd0, Valid},    32'd1);
      check("stall.count",    {28'd0, RetireCount}, 32'd0);
    end
    Flush = 1'b1; step();
    check("flush.valid",    {31'd0, Valid},    32'd0);
    check("flush.regwrite", {31'd0, RegWrite}, 32'd0);
    check("flush.regdst",   {27'd0, RegDst},   32'd0);
    check("flush.wdata",    WriteData,         32'd0);
    check("flush.count",    {28'd0, RetireCount}, 32'd1);
    Stall = 1'b0; Flush = 1'b0;
    step();
    check("postflush.count", {28'd0, RetireCount}, {28'd0, exp_cnt});

    // 6. Counter saturates at 15 over 20 back-to-back instructions.
    pulse_reset();
    for (int k = 1; k <= 20; k++) begin
      drive(1, 1, 0, 0, 2'b10, 0, 5'd4, k, 32'h0, 32'h0); step();
      check($sformatf("sat.count%0d", k), {28'd0, RetireCount},
            (k - 1 > 15) ? 32'd15 : 32'(k - 1));
    end
    check("sat.model", {28'd0, RetireCount}, {28'd0, exp_cnt});

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
